pixel_sink: RTL and testbench
=============================

PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 The block SHALL provide parameter H_ACTIVE, default 640, visible pixel clocks per line.
REQ-002 The block SHALL provide parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixel clocks.
REQ-003 The block SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The block SHALL provide parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 Port: clock  in  1  system clock; all state changes on its rising edge.
REQ-006 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: plot  in  1  pixel write strobe, one write per high cycle.
REQ-008 Port: x  in  8  write column, valid 0..159.
REQ-009 Port: y  in  7  write row, valid 0..119.
REQ-010 Port: colour  in  3  write colour {R,G,B}.
REQ-011 Port: clear_req  in  1  request a full-buffer fill.
REQ-012 Port: clear_colour  in  3  fill colour, sampled with clear_req.
REQ-013 Port: busy  out  1  fill in progress.
REQ-014 Port: drop_count  out  8  count of rejected writes, saturating.
REQ-015 Port: vga_rgb, vga_hs, vga_vs, vga_blank_n  out  3/1/1/1  video outputs; syncs active-low.

Function
REQ-016 Pixel tick: an internal toggle flop SHALL assert pix_en on every second clock, the first on the second clock after reset release.
REQ-017 hcnt SHALL advance on pix_en over 0..H_total-1 (800); at wrap, vcnt SHALL advance over 0..V_total-1 (525) and wrap to 0.
REQ-018 Active region SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE; hs low for hcnt in [656,751]; vs low for vcnt in [490,491].
REQ-019 Read address SHALL be (vcnt>>2)*160+(hcnt>>2), giving 4x scaling of the 160x120 buffer.
REQ-020 Read SHALL be registered; vga_hs, vga_vs and vga_blank_n SHALL be delayed one pix_en so they align with vga_rgb.
REQ-021 vga_rgb SHALL be 3'b000 whenever vga_blank_n is low.
REQ-022 A write SHALL occur when plot=1, x<160, y<120 and busy=0: mem[y*160+x] <= colour on that edge.
REQ-023 When plot=1 and the write is out of range or busy=1, the write SHALL be dropped and drop_count incremented, holding at 255.
REQ-024 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-025 Fill FSM states SHALL be IDLE and FILL; clear_req in IDLE SHALL latch clear_colour and enter FILL next cycle with busy=1.
REQ-026 FILL SHALL write addresses 0..19199, one per clock; after address 19199 it SHALL return to IDLE with busy=0, for exactly 19200 busy cycles.
REQ-027 clear_req during FILL SHALL be ignored; scan-out SHALL continue during FILL.

Reset
REQ-028 Reset SHALL set hcnt=vcnt=0, pix_en phase 0, vga_hs=vga_vs=1, vga_blank_n=0, vga_rgb=0, busy=0, drop_count=0, FSM=IDLE.
REQ-029 Reset during FILL SHALL abort the fill; buffer contents are not reset and are undefined until written.

Configuration
REQ-030 With macro PIXEL_SINK_FILL_EN defined, REQ-025..027 SHALL apply.
REQ-031 Without PIXEL_SINK_FILL_EN, the fill FSM SHALL be absent, clear_req and clear_colour ignored, and busy tied to 0.

Structure
REQ-032 Package pixel_sink_pkg SHALL hold FB_W=160, FB_H=120, FB_DEPTH=19200, FB_AW=15, the colour_t 3-bit typedef and the VGA timing defaults.
REQ-033 Sub-module pixel_sink_timing SHALL contain pix_en, hcnt/vcnt, sync and active decode; the memory and fill FSM SHALL be in pixel_sink.

Verification
REQ-034 Plot (x=60,y=40,colour=3'b100), then scan the frame -> vga_rgb=3'b100 exactly for hcnt 240..243, vcnt 160..163; elsewhere the prior contents.
REQ-035 Plot x=160, then y=120, then x=200 -> buffer unchanged, drop_count=3; 260 invalid plots -> drop_count=255.
REQ-036 Pulse clear_req with clear_colour=3'b010 -> busy high for 19200 cycles, then the whole frame reads 3'b010; a plot during busy -> dropped and counted.
REQ-037 Free-run two frames -> hs period 1600 clocks, hs low 192 clocks, vs low 2 lines, blank_n high 640 px x 480 lines, rgb=0 while blanked.
REQ-038 Assert reset_n low mid-fill at address 5000 -> busy=0 immediately, FSM IDLE, syncs high; a new clear_req after release restarts the fill from address 0.
REQ-039 Build without PIXEL_SINK_FILL_EN; pulse clear_req -> busy stays 0 and contents are unchanged.

Source files
------------

// File: rtl/pixel_sink_pkg.sv
// -----------------------------------------------------------------------------
// pixel_sink_pkg
// Shared constants and types for the pixel_sink frame-buffer video sink:
// frame-buffer geometry (160x120, 3-bit colour), counter width, default VGA
// 640x480 timing, the fill FSM state type and the buffer address helper.
// -----------------------------------------------------------------------------
package pixel_sink_pkg;

    // Frame-buffer geometry
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = 19200;
    localparam int FB_AW    = 15;

    // Width of the horizontal / vertical scan counters
    localparam int CNT_W = 12;

    // Default VGA 640x480 timing (pixel clocks / lines)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [2:0] colour_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // Linear buffer address of (col,row): row * FB_W + col
    function automatic logic [FB_AW-1:0] fb_addr(input logic [9:0] col,
                                                 input logic [9:0] row);
        return FB_AW'(row) * FB_AW'(FB_W) + FB_AW'(col);
    endfunction

endpackage

// File: rtl/pixel_sink_timing.sv
// -----------------------------------------------------------------------------
// pixel_sink_timing
// Pixel-rate tick plus VGA scan counters and sync/active decode.
//   clock, reset_n : system clock, async active-low reset
//   pix_en         : high every second clock (first on the 2nd clock after reset)
//   hcnt, vcnt     : current scan position
//   hs_n, vs_n     : active-low sync decode of the current position
//   active         : current position lies inside the visible area
// The decodes are combinational; the parent registers them on pix_en.
// -----------------------------------------------------------------------------
module pixel_sink_timing
    import pixel_sink_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs_n,
    output logic             vs_n,
    output logic             active
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    // Sync windows: [start, end) in counter units
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    // Next-state for the pixel tick and the raster counters
    always_comb begin
        phase_d = ~phase_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (phase_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = CNT_W'(0);
                if (vcnt_q == V_LAST) begin
                    vcnt_d = CNT_W'(0);
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Tick and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            hcnt_q  <= CNT_W'(0);
            vcnt_q  <= CNT_W'(0);
        end else begin
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign pix_en = phase_q;
    assign hcnt   = hcnt_q;
    assign vcnt   = vcnt_q;
    assign hs_n   = !((hcnt_q >= H_SS) && (hcnt_q < H_SE));
    assign vs_n   = !((vcnt_q >= V_SS) && (vcnt_q < V_SE));
    assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

endmodule

// File: rtl/pixel_sink.sv
// -----------------------------------------------------------------------------
// pixel_sink
// 160x120x3 frame buffer written by a pixel-plot port and scanned out 4x
// scaled as VGA video.
//   clock, reset_n          : system clock, async active-low reset
//   plot, x, y, colour      : pixel write strobe / column / row / {R,G,B}
//   clear_req, clear_colour : request a whole-buffer fill with clear_colour
//   busy                    : fill in progress (plots are dropped meanwhile)
//   drop_count              : saturating count of rejected plots
//   vga_rgb, vga_hs, vga_vs, vga_blank_n : video out, syncs active-low
// Build option: define PIXEL_SINK_FILL_EN to include the fill FSM; without it
// clear_req/clear_colour are ignored and busy is constant 0.
// -----------------------------------------------------------------------------
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       clear_req,
    input  logic [2:0] clear_colour,
    output logic       busy,
    output logic [7:0] drop_count,
    output logic [2:0] vga_rgb,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
);

    localparam logic [7:0] X_LIM = 8'(FB_W);
    localparam logic [6:0] Y_LIM = 7'(FB_H);

    logic             pix_en_s;
    logic [CNT_W-1:0] hcnt_s, vcnt_s;
    logic             hs_n_s, vs_n_s, active_s;

    colour_t          mem_q [FB_DEPTH];
    colour_t          rd_data_q;
    logic [FB_AW-1:0] rd_addr_s, wr_addr_s;
    colour_t          wr_data_s;
    logic             wr_en_s, busy_s, in_range_s;
    logic [7:0]       drop_q, drop_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic             unused_s;

    pixel_sink_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock  (clock),
        .reset_n(reset_n),
        .pix_en (pix_en_s),
        .hcnt   (hcnt_s),
        .vcnt   (vcnt_s),
        .hs_n   (hs_n_s),
        .vs_n   (vs_n_s),
        .active (active_s)
    );

    // Dropping the two LSBs of each counter gives the 4x pixel replication;
    // outside the visible area the address is parked at 0.
    assign rd_addr_s  = active_s ? fb_addr(hcnt_s[CNT_W-1:2], vcnt_s[CNT_W-1:2])
                                 : FB_AW'(0);
    assign in_range_s = (x < X_LIM) && (y < Y_LIM);

`ifdef PIXEL_SINK_FILL_EN
    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_DEPTH - 1);

    fill_state_t      state_q, state_d;
    logic [FB_AW-1:0] fill_addr_q, fill_addr_d;
    colour_t          fill_colour_q, fill_colour_d;

    // Fill FSM next-state: clear_req is only honoured in IDLE
    always_comb begin
        state_d       = state_q;
        fill_addr_d   = fill_addr_q;
        fill_colour_d = fill_colour_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d       = ST_FILL;
                    fill_addr_d   = FB_AW'(0);
                    fill_colour_d = clear_colour;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_addr_q == FB_LAST) begin
                    state_d     = ST_IDLE;
                    fill_addr_d = FB_AW'(0);
                end else begin
                    fill_addr_d = fill_addr_q + FB_AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fill FSM registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            fill_addr_q   <= FB_AW'(0);
            fill_colour_q <= 3'b000;
        end else begin
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_colour_q <= fill_colour_d;
        end
    end

    assign busy_s   = (state_q == ST_FILL);
    assign unused_s = ^{hcnt_s[1:0], vcnt_s[1:0]};

    // Write-port select: the fill owns the port while busy
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = FB_AW'(0);
        wr_data_s = 3'b000;
        if (busy_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = fill_addr_q;
            wr_data_s = fill_colour_q;
        end else if (plot && in_range_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = fb_addr({2'b00, x}, {3'b000, y});
            wr_data_s = colour;
        end else begin
            wr_en_s = 1'b0;
        end
    end
`else
    assign busy_s   = 1'b0;
    assign unused_s = ^{hcnt_s[1:0], vcnt_s[1:0], clear_req, clear_colour};

    // Write-port select: plots only
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = FB_AW'(0);
        wr_data_s = 3'b000;
        if (plot && in_range_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = fb_addr({2'b00, x}, {3'b000, y});
            wr_data_s = colour;
        end else begin
            wr_en_s = 1'b0;
        end
    end
`endif

    // Rejected-plot counter, saturating at 255
    always_comb begin
        drop_d = drop_q;
        if (plot && (!in_range_s || busy_s) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Sync/blank are delayed one pixel tick to line up with the registered read
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        if (pix_en_s) begin
            hs_d    = hs_n_s;
            vs_d    = vs_n_s;
            blank_d = active_s;
        end else begin
            hs_d    = hs_q;
            vs_d    = vs_q;
            blank_d = blank_q;
        end
    end

    // Control and video-timing registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q  <= 8'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            drop_q  <= drop_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

    // Frame-buffer RAM; a same-edge read of the written address sees old data
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
        if (pix_en_s) begin
            rd_data_q <= mem_q[rd_addr_s];
        end
    end

    assign busy        = busy_s;
    assign drop_count  = drop_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    // blank_q resets low, so the unreset RAM read data never reaches the pins
    assign vga_rgb     = rd_data_q & {3{blank_q}};

endmodule

// File: tb/tb_pixel_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_sink
// Scoreboard bench for pixel_sink with a reduced raster (48x32 visible) so
// full frames stay short. A reference model derives every video pixel from
// an absolute pixel index and a reference copy of the buffer and queues the
// expectation; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pixel_sink;

    localparam int HA = 48, HF = 4, HS = 8, HB = 4;
    localparam int VA = 32, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = 2 * HT * VT;
    localparam int DEPTH = 19200;
`ifdef PIXEL_SINK_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic       clock, reset_n, plot, clear_req;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour, clear_colour;
    logic       busy;
    logic [7:0] drop_count;
    logic [2:0] vga_rgb;
    logic       vga_hs, vga_vs, vga_blank_n;

    pixel_sink #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .plot(plot), .x(x), .y(y),
        .colour(colour), .clear_req(clear_req), .clear_colour(clear_colour),
        .busy(busy), .drop_count(drop_count), .vga_rgb(vga_rgb),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       bl;
        bit         chk;
        int         pix;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] ref_fb [DEPTH];
    bit         known [DEPTH];
    int         edge_cnt, fill_rem, model_drop;
    logic [2:0] fill_col;
    bit         model_busy;
    int         total, bad;

    // Reference model, one step per rising edge
    task automatic model_step();
        exp_t e;
        int   p, h, v, a;
        bit   busy_now;
        if (!reset_n) begin
            edge_cnt   = 0;
            fill_rem   = 0;
            model_drop = 0;
            model_busy = 1'b0;
            exp_q.delete();
        end else begin
            busy_now = (fill_rem > 0);
            edge_cnt++;
            // every second edge after release emits pixel (edge_cnt/2 - 1)
            if (edge_cnt % 2 == 0) begin
                p     = edge_cnt / 2 - 1;
                h     = p % HT;
                v     = (p / HT) % VT;
                e.bl  = (h < HA) && (v < VA);
                e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
                e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
                e.rgb = 3'b000;
                e.chk = 1'b1;
                e.pix = p;
                if (e.bl) begin
                    a     = (v / 4) * 160 + h / 4;
                    e.rgb = ref_fb[a];
                    e.chk = known[a];
                end
                exp_q.push_back(e);
            end
            if (plot) begin
                if (x < 160 && y < 120 && !busy_now) begin
                    a         = int'(y) * 160 + int'(x);
                    ref_fb[a] = colour;
                    known[a]  = 1'b1;
                end else if (model_drop < 255) begin
                    model_drop++;
                end
            end
            if (busy_now) begin
                ref_fb[DEPTH - fill_rem] = fill_col;
                known[DEPTH - fill_rem]  = 1'b1;
                fill_rem--;
            end else if (FILL_EN && clear_req) begin
                fill_rem = DEPTH;
                fill_col = clear_colour;
            end
            model_busy = (fill_rem > 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Monitor: compare video outputs and busy away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    total++;
                    if (vga_hs !== mon_e.hs || vga_vs !== mon_e.vs ||
                        vga_blank_n !== mon_e.bl ||
                        (mon_e.chk && vga_rgb !== mon_e.rgb)) begin
                        bad++;
                        $display("FAIL video px=%0d got rgb=%0d hs=%0b vs=%0b bl=%0b want rgb=%0d hs=%0b vs=%0b bl=%0b",
                                 mon_e.pix, vga_rgb, vga_hs, vga_vs, vga_blank_n,
                                 mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bl);
                    end
                end
                total++;
                if (busy !== model_busy) begin
                    bad++;
                    $display("FAIL busy at %0t: got %0b want %0b", $time, busy, model_busy);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_plot(input int px, input int py, input logic [2:0] c);
        @(negedge clock);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = c;
    endtask

    task automatic go_idle();
        @(negedge clock);
        plot      = 1'b0;
        clear_req = 1'b0;
    endtask

    // Issue a clear, inject a plot on the first busy cycle and a second
    // clear_req mid-fill, and count the busy cycles
    task automatic clear_and_count(input logic [2:0] c, output int bc);
        int  n;
        bit  done;
        @(negedge clock);
        clear_req    = 1'b1;
        clear_colour = c;
        @(negedge clock);
        clear_req = 1'b0;
        plot      = 1'b1;
        x         = 8'd3;
        y         = 7'd3;
        colour    = 3'b111;
        bc   = 0;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            if (busy) bc++;
            @(negedge clock);
            plot         = 1'b0;
            clear_req    = (n == 100);
            clear_colour = 3'b111;
            n++;
            if (!busy && (bc > 0 || n > 50)) done = 1'b1;
            if (n >= 25000) begin
                done = 1'b1;
                total++;
                bad++;
                $display("FAIL busy_timeout: got busy still high after %0d cycles want low", n);
            end
        end
        clear_req = 1'b0;
    endtask

    int bc;
    int cnt, n;

    initial begin
        plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'b000;
        clear_req = 1'b0; clear_colour = 3'b000;
        total = 0; bad = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_hs", vga_hs, 1);
        check("reset_vs", vga_vs, 1);
        check("reset_blank_n", vga_blank_n, 0);
        check("reset_rgb", vga_rgb, 0);
        check("reset_busy", busy, 0);
        check("reset_drop", drop_count, 0);
        reset_n = 1'b1;

        // Populate the visible part of the buffer, then the single marker pixel
        for (int yy = 0; yy < VA / 4; yy++)
            for (int xx = 0; xx < HA / 4; xx++)
                do_plot(xx, yy, 3'($urandom_range(0, 7)));
        do_plot(6, 4, 3'b100);
        // Each coordinate just past its limit, then well past
        do_plot(160, 5, 3'b001);
        do_plot(5, 120, 3'b001);
        do_plot(200, 5, 3'b001);
        go_idle();
        check("drop_after_3", drop_count, 3);
        repeat (FRAME_CLKS + 8) @(negedge clock);

        // Whole-buffer clear with a plot during busy
        clear_and_count(3'b010, bc);
        check("fill_busy_cycles", bc, FILL_EN ? DEPTH : 0);
        check("drop_after_busy_plot", drop_count, FILL_EN ? 4 : 3);
        repeat (FRAME_CLKS + 8) @(negedge clock);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++)
            do_plot($urandom_range(160, 255), $urandom_range(0, 127), 3'b111);
        go_idle();
        check("drop_saturated", drop_count, 255);

        // Random plot traffic while the frame scans
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge clock);
            plot   = ($urandom_range(0, 2) == 0);
            x      = ($urandom_range(0, 15) == 0) ? 8'd170 : 8'($urandom_range(0, 13));
            y      = 7'($urandom_range(0, 9));
            colour = 3'($urandom_range(0, 7));
        end
        go_idle();

`ifdef PIXEL_SINK_FILL_EN
        // Reset in the middle of a fill, then restart the fill
        @(negedge clock);
        clear_req    = 1'b1;
        clear_colour = 3'b011;
        cnt = 0;
        n   = 0;
        while (cnt < 5000 && n < 25000) begin
            @(negedge clock);
            clear_req = 1'b0;
            n++;
            if (busy) cnt++;
        end
        check("fill_reached_5000", cnt, 5000);
        #1 reset_n = 1'b0;
        #1;
        check("midfill_reset_busy", busy, 0);
        check("midfill_reset_hs", vga_hs, 1);
        check("midfill_reset_vs", vga_vs, 1);
        check("midfill_reset_blank_n", vga_blank_n, 0);
        repeat (2) @(negedge clock);
        check("midfill_reset_busy_held", busy, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("drop_after_reset", drop_count, 0);
        clear_and_count(3'b101, bc);
        check("refill_busy_cycles", bc, DEPTH);
        repeat (FRAME_CLKS + 8) @(negedge clock);
`else
        // Without the fill FSM a clear request must do nothing
        clear_and_count(3'b011, bc);
        check("nofill_busy_cycles", bc, 0);
        repeat (FRAME_CLKS + 8) @(negedge clock);
`endif
        check("drop_final", drop_count, model_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
